tl_cntr_w_left: RTL and testbench
=================================

Name: tl_cntr_w_left

Overview:
- Moore-type traffic light controller for a two-road intersection (road A, road B), each with a protected left-turn phase.
- Eight-state FSM cycles A-green, A-yellow, A-left, A-yellow, B-green, B-yellow, B-left, B-yellow.
- Each green/left phase dwells while its traffic sensor is asserted.
- Standalone leaf block; drives the two 2-bit lamp codes.

Parameters:
- none. Lamp and state encodings are fixed constants; see Decomposition.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset_n  input  1  synchronous, active-high reset (asserted when 1, sampled on the clk rising edge).
- Ta  input  1  road A straight-traffic sensor; 1 = cars waiting/flowing.
- Tal  input  1  road A left-turn sensor.
- Tb  input  1  road B straight-traffic sensor.
- Tbl  input  1  road B left-turn sensor.
- La  output  2  road A lamp code.
- Lb  output  2  road B lamp code.

Behaviour:
- Lamp encoding: GREEN=2'b00, YELLOW=2'b01, RED=2'b10, LEFT=2'b11.
- State register: 3 bits, states S0..S7 encoded 3'd0..3'd7.
- Reset: when reset_n=1 at a rising clk edge, state <= S0. Outputs then read La=GREEN(00), Lb=RED(10). Reset overrides all transitions, including mid-cycle from any state.
- Transitions (evaluated at each rising edge with reset_n=0):
  - S0 (A green): Ta=1 -> stay in S0; Ta=0 -> S1.
  - S1 (A yellow): -> S2 unconditionally.
  - S2 (A left): Tal=1 -> stay; Tal=0 -> S3.
  - S3 (A yellow): -> S4 unconditionally.
  - S4 (B green): Tb=1 -> stay; Tb=0 -> S5.
  - S5 (B yellow): -> S6 unconditionally.
  - S6 (B left): Tbl=1 -> stay; Tbl=0 -> S7.
  - S7 (B yellow): -> S0 unconditionally.
- Outputs are a pure function of the current state (Moore); no combinational path from the sensor inputs to La/Lb.
  - S0: La=00, Lb=10
  - S1: La=01, Lb=10
  - S2: La=11, Lb=10
  - S3: La=01, Lb=10
  - S4: La=10, Lb=00
  - S5: La=10, Lb=01
  - S6: La=10, Lb=11
  - S7: La=10, Lb=01
- Safety invariant: at least one road is RED in every state; never both non-RED.
- Only the sensor belonging to the current dwell state matters. Other sensors are ignored, even when several are asserted at once.
- Yellow states last exactly one clock.
- Minimum phase length is one clock: a sensor already 0 on entry leaves after one cycle.
- Latency: a sensor change seen at edge N changes the lamps immediately after edge N.
- Unreachable/illegal state encodings do not exist with 3 bits. The default branch still recovers to S0.

Decomposition:
- Shared package tl_pkg holds:
  - lamp-code constants GREEN, YELLOW, RED, LEFT (2-bit);
  - state constants S0..S7 (3-bit), or an enum typedef for them.
- Natural split into three pieces:
  - next-state combinational logic;
  - 3-bit state register with synchronous reset;
  - output decoder, as sub-module tl_out_decoder (state in -> La, Lb).

Test Plan:
- Reset: hold reset_n=1 for 2 edges with all sensors 0 -> state S0, La=00, Lb=10. Release reset with all sensors 0 -> full loop S1..S7 back to S0 in 8 clocks. Lamp sequence A: 00,01,11,01,10,10,10,10; B: 10,10,10,10,00,01,11,01.
- A dwell: in S0 hold Ta=1 for 3 edges -> La stays 00. Drop Ta -> next edge La=01, following edge La=11.
- Left dwells: in S2 hold Tal=1 for 2 edges -> La=11 held; Tal=0 -> S3 (La=01) -> S4 (La=10, Lb=00). Repeat for S6 with Tbl: Lb=11 held, then 01, then back to S0.
- Sensor isolation: in S4 drive Ta=Tal=Tbl=1, Tb=0 -> advances to S5 (Lb=01) next edge; the non-owning sensors have no effect.
- Reset mid-operation: in S6 (Lb=11) assert reset_n=1 for one edge -> La=00, Lb=10 right after that edge.
- Invariant check every cycle: La==10 || Lb==10.

Source files
------------

// File: rtl/tl_pkg.sv
// Shared lamp codes and FSM state encoding for the left-turn traffic light controller.
package tl_pkg;

  localparam logic [1:0] GREEN  = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] RED    = 2'b10;
  localparam logic [1:0] LEFT   = 2'b11;

  // S0 A-green, S1 A-yellow, S2 A-left, S3 A-yellow,
  // S4 B-green, S5 B-yellow, S6 B-left, S7 B-yellow.
  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4,
    S5 = 3'd5,
    S6 = 3'd6,
    S7 = 3'd7
  } state_t;

endpackage

// File: rtl/tl_out_decoder.sv
// Moore output decoder: maps the current state to both roads' lamp codes.
module tl_out_decoder
  import tl_pkg::*;
(
  input  state_t     state,
  output logic [1:0] La,
  output logic [1:0] Lb
);

  // Pure state decode; whichever road is not in its phase is held RED.
  always_comb begin
    La = RED;
    Lb = RED;
    case (state)
      S0:      La = GREEN;
      S1:      La = YELLOW;
      S2:      La = LEFT;
      S3:      La = YELLOW;
      S4:      Lb = GREEN;
      S5:      Lb = YELLOW;
      S6:      Lb = LEFT;
      S7:      Lb = YELLOW;
      default: begin
        La = RED;
        Lb = RED;
      end
    endcase
  end

endmodule

// File: rtl/tl_cntr_w_left.sv
// Two-road traffic light controller with protected left-turn phases.
// reset_n is active-high despite its name; the port name is kept as-is.
module tl_cntr_w_left
  import tl_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       Ta,
  input  logic       Tal,
  input  logic       Tb,
  input  logic       Tbl,
  output logic [1:0] La,
  output logic [1:0] Lb
);

  state_t state;
  state_t next;

  // State register with synchronous active-high reset to A-green.
  always_ff @(posedge clk) begin
    if (reset_n) state <= S0;
    else         state <= next;
  end

  // Next-state: dwell phases wait on their own sensor, yellows last one clock.
  always_comb begin
    next = state;
    case (state)
      S0:      if (!Ta)  next = S1;
      S1:      next = S2;
      S2:      if (!Tal) next = S3;
      S3:      next = S4;
      S4:      if (!Tb)  next = S5;
      S5:      next = S6;
      S6:      if (!Tbl) next = S7;
      S7:      next = S0;
      default: next = S0;
    endcase
  end

  // Lamp decode from the registered state only.
  tl_out_decoder u_out_decoder (
    .state (state),
    .La    (La),
    .Lb    (Lb)
  );

endmodule

// File: tb/tb_tl_cntr_w_left.sv
// Self-checking bench for tl_cntr_w_left: directed vector table plus random
// sensor traffic checked against a phase-list reference model.
module tb_tl_cntr_w_left;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       Ta = 1'b0, Tal = 1'b0, Tb = 1'b0, Tbl = 1'b0;
  logic [1:0] La, Lb;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  tl_cntr_w_left dut (
    .clk     (clk),
    .reset_n (reset_n),
    .Ta      (Ta),
    .Tal     (Tal),
    .Tb      (Tb),
    .Tbl     (Tbl),
    .La      (La),
    .Lb      (Lb)
  );

  always #5 clk = ~clk;

  // Reference model: the cycle is a list of eight phases, each with its lamp
  // pair and the sensor that may hold it (-1 = yellow, always leaves).
  logic [1:0] ph_la [8] = '{2'b00, 2'b01, 2'b11, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10};
  logic [1:0] ph_lb [8] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01, 2'b11, 2'b01};
  int         ph_own[8] = '{0, -1, 1, -1, 2, -1, 3, -1};
  int         pos = 0;

  function automatic void model_step(input logic rst, input logic [3:0] sens);
    if (rst) pos = 0;
    else if (ph_own[pos] < 0 || !sens[ph_own[pos]]) pos = (pos + 1) % 8;
  endfunction

  task automatic check2(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, clock it, then sample away from the edge.
  task automatic step(input logic rst, input logic ta, input logic tal,
                      input logic tb, input logic tbl);
    @(negedge clk);
    reset_n = rst; Ta = ta; Tal = tal; Tb = tb; Tbl = tbl;
    @(posedge clk);
    #1;
    model_step(rst, {tbl, tb, tal, ta});
    n_cmp++;
    if (!(La == 2'b10 || Lb == 2'b10)) begin
      n_bad++;
      $display("FAIL invariant: La=%b Lb=%b, one must be 10", La, Lb);
    end
  endtask

  typedef struct {
    logic       rst, ta, tal, tb, tbl;
    logic [1:0] la, lb;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic ta, input logic tal,
                              input logic tb, input logic tbl,
                              input logic [1:0] la, input logic [1:0] lb);
    vec_t v;
    v.rst = rst; v.ta = ta; v.tal = tal; v.tb = tb; v.tbl = tbl;
    v.la = la; v.lb = lb;
    return v;
  endfunction

  initial begin
    // Reset for two edges.
    vecs.push_back(mk(1,0,0,0,0, 2'b00,2'b10));
    vecs.push_back(mk(1,0,0,0,0, 2'b00,2'b10));
    // Free-running loop with sensors idle.
    vecs.push_back(mk(0,0,0,0,0, 2'b01,2'b10));
    vecs.push_back(mk(0,0,0,0,0, 2'b11,2'b10));
    vecs.push_back(mk(0,0,0,0,0, 2'b01,2'b10));
    vecs.push_back(mk(0,0,0,0,0, 2'b10,2'b00));
    vecs.push_back(mk(0,0,0,0,0, 2'b10,2'b01));
    vecs.push_back(mk(0,0,0,0,0, 2'b10,2'b11));
    vecs.push_back(mk(0,0,0,0,0, 2'b10,2'b01));
    vecs.push_back(mk(0,0,0,0,0, 2'b00,2'b10));
    // A-green dwell, then release.
    vecs.push_back(mk(0,1,0,0,0, 2'b00,2'b10));
    vecs.push_back(mk(0,1,0,0,0, 2'b00,2'b10));
    vecs.push_back(mk(0,1,0,0,0, 2'b00,2'b10));
    vecs.push_back(mk(0,0,0,0,0, 2'b01,2'b10));
    vecs.push_back(mk(0,0,1,0,0, 2'b11,2'b10));
    // A-left dwell.
    vecs.push_back(mk(0,0,1,0,0, 2'b11,2'b10));
    vecs.push_back(mk(0,0,1,0,0, 2'b11,2'b10));
    vecs.push_back(mk(0,0,0,0,0, 2'b01,2'b10));
    vecs.push_back(mk(0,0,0,1,0, 2'b10,2'b00));
    // In B-green, only Tb counts.
    vecs.push_back(mk(0,1,1,0,1, 2'b10,2'b01));
    vecs.push_back(mk(0,0,0,0,1, 2'b10,2'b11));
    // B-left dwell.
    vecs.push_back(mk(0,0,0,0,1, 2'b10,2'b11));
    vecs.push_back(mk(0,0,0,0,1, 2'b10,2'b11));
    vecs.push_back(mk(0,0,0,0,0, 2'b10,2'b01));
    vecs.push_back(mk(0,0,0,0,0, 2'b00,2'b10));
    // In A-green, other sensors asserted don't hold it.
    vecs.push_back(mk(0,0,1,1,1, 2'b01,2'b10));
    vecs.push_back(mk(0,0,0,0,0, 2'b11,2'b10));
    vecs.push_back(mk(0,0,0,0,0, 2'b01,2'b10));
    vecs.push_back(mk(0,0,0,0,0, 2'b10,2'b00));
    vecs.push_back(mk(0,0,0,0,0, 2'b10,2'b01));
    vecs.push_back(mk(0,0,0,0,0, 2'b10,2'b11));
    // Reset in B-left overrides the dwell.
    vecs.push_back(mk(1,1,1,1,1, 2'b00,2'b10));
    vecs.push_back(mk(0,1,0,0,0, 2'b00,2'b10));

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].ta, vecs[i].tal, vecs[i].tb, vecs[i].tbl);
      check2($sformatf("vec%0d_La", i), La, vecs[i].la);
      check2($sformatf("vec%0d_Lb", i), Lb, vecs[i].lb);
    end

    // Random sensors with occasional resets, against the model.
    for (int i = 0; i < 400; i++) begin
      logic r;
      logic [3:0] s;
      r = ($urandom_range(0, 39) == 0);
      s = 4'($urandom);
      step(r, s[0], s[1], s[2], s[3]);
      check2($sformatf("rnd%0d_La", i), La, ph_la[pos]);
      check2($sformatf("rnd%0d_Lb", i), Lb, ph_lb[pos]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
